// File: rtl/div_unit.sv
// RV32M restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle; ready in cycle XLEN+1, div-by-zero/overflow in cycle 1.
// No backpressure: result is offered for the single ready cycle; dropping enable while busy aborts the operation.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rem_sel;
  logic            neg_quo;
  logic            neg_rem;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;

  // Request decode, only meaningful in IDLE
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            overflow;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & rdata1[XLEN-1];
    b_neg     = is_signed & rdata2[XLEN-1];
    abs_a     = a_neg ? -rdata1 : rdata1;
    abs_b     = b_neg ? -rdata2 : rdata2;
    div_zero  = (rdata2 == '0);
    overflow  = is_signed && (rdata1 == INT_MIN) && (rdata2 == '1);
  end

  // One restoring step; the shifted remainder needs one extra bit before the trial subtract
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] new_rem;
  logic [XLEN-1:0] new_quo;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    new_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    new_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
    fin_quo = neg_quo ? -new_quo : new_quo;
    fin_rem = neg_rem ? -new_rem : new_rem;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem_sel <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (enable) begin
            rem_sel <= op[1];
            neg_quo <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (div_zero) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= op[1] ? rdata1 : '1;
            end else if (overflow) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= op[1] ? '0 : INT_MIN;
            end else begin
              state <= BUSY;
              cnt   <= CW'(XLEN);
              rem_q <= '0;
              quo_q <= abs_a;
              dvs_q <= abs_b;
            end
          end
        end
        BUSY: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            rem_q <= new_rem;
            quo_q <= new_quo;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= rem_sel ? fin_rem : fin_quo;
            end
          end
        end
        DONE: begin
          // enable ignored here so a still-held request is not recomputed
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: directed RV32M corner cases, latency, abort, reset, back-to-back and random ops.
module tb_div_unit;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rdata1 = '0;
  logic [31:0] rdata2 = '0;
  logic [31:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] last_exp = '0;

  div_unit #(.XLEN(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .op     (op),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .result (result),
    .ready  (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      OP_DIV:  return $signed(a) / $signed(b);
      OP_DIVU: return a / b;
      OP_REM:  return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Result checking happens here, one pop per ready pulse
  always @(negedge clock) begin
    if (reset && ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", {31'b0, ready}, 32'd0);
      end else begin
        check(tag_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the ready cycle
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit scramble);
    int cyc;
    enable = 1'b1;
    op     = o;
    rdata1 = a;
    rdata2 = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    last_exp = exp;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (ready) break;
      if (scramble) begin
        rdata1 = $urandom;
        rdata2 = $urandom;
        op     = 2'($urandom_range(0, 3));
      end
    end
    if (!ready) begin
      check({tag, "_timeout"}, 32'(cyc), 32'(exp_lat));
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end else begin
      check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    @(negedge clock);
    check("no_second_pulse", {31'b0, ready}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0); go_idle();
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0); go_idle();

    run_op("div_m7_2",   OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0); go_idle();
    run_op("rem_m7_2",   OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0); go_idle();
    run_op("div_m7_m2",  OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33, 1'b0); go_idle();
    run_op("rem_7_m2",   OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0); go_idle();

    run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0); go_idle();
    run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0); go_idle();
    run_op("divu_0_0",   OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, 1'b0); go_idle();
    run_op("rem_m7_0",   OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 1'b0); go_idle();

    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0); go_idle();
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0); go_idle();
    run_op("divu_ovf",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0); go_idle();

    // Abort: drop enable in cycle 10, nothing may complete afterwards
    enable = 1'b1; op = OP_DIVU; rdata1 = 32'h1234_5678; rdata2 = 32'd3;
    repeat (10) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("abort_ready", {31'b0, ready}, 32'd0);
    repeat (30) @(negedge clock);
    check("abort_result", result, last_exp);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0); go_idle();

    // Asynchronous reset mid-operation, checked between clock edges
    enable = 1'b1; op = OP_DIVU; rdata1 = 32'd1000; rdata2 = 32'd3;
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    check("async_rst_ready", {31'b0, ready}, 32'd0);
    check("async_rst_result", result, 32'd0);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Back-to-back with operands scrambled while busy and enable held through DONE
    run_op("b2b_divu", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
    @(negedge clock);
    check("b2b_gap_ready", {31'b0, ready}, 32'd0);
    run_op("b2b_remu", OP_REMU, 32'd10, 32'd4, 32'd2, 33, 1'b1); go_idle();

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case (i % 4)
        0: b = 32'($urandom_range(1, 15));
        1: b = $urandom;
        2: b = -32'($urandom_range(1, 100));
        default: b = a >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rand%0d", i), o, a, b, model(o, a, b), model_lat(o, a, b), 1'b0);
      go_idle();
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
